wb_stage: RTL and testbench

//  Write-back stage. Sits between MEM/WB and the register file write port.

---
 rtl/wb_if.sv | 26 ++
 rtl/wb_stage.sv | 65 ++++++
 tb/tb_wb_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wb_if.sv
// wb_if: MEM/WB, data-memory read and register-file write signals of the write-back stage
interface wb_if #(parameter int DATA_SIZE = 32, parameter int CNT_SIZE = 32);
  logic                 mem_valid;
  logic                 mem_reg_write;
  logic                 mem_to_reg;
  logic [4:0]           mem_rd_addr;
  logic [DATA_SIZE-1:0] mem_alu_result;
  logic [2:0]           mem_funct3;
  logic [DATA_SIZE-1:0] dm_rdata;
  logic                 dm_rvalid;
  logic                 wb_stall;
  logic                 write_reg;
  logic [4:0]           rd_addr;
  logic [DATA_SIZE-1:0] write_data;
  logic [CNT_SIZE-1:0]  retire_cnt;
  modport slave (
    input  mem_valid, mem_reg_write, mem_to_reg, mem_rd_addr, mem_alu_result, mem_funct3,
           dm_rdata, dm_rvalid,
    output wb_stall, write_reg, rd_addr, write_data, retire_cnt
  );
  modport master (
    output mem_valid, mem_reg_write, mem_to_reg, mem_rd_addr, mem_alu_result, mem_funct3,
           dm_rdata, dm_rvalid,
    input  wb_stall, write_reg, rd_addr, write_data, retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: write-back stage retiring ALU results and extended load data into the register file
module wb_stage #(
  parameter int DATA_SIZE = 32,
  parameter int CNT_SIZE  = 32
) (
  input logic clk,
  input logic rst,
  wb_if.slave bus
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t               state;
  logic                 ld_we;
  logic [4:0]           ld_rd;
  logic [2:0]           ld_f3;
  logic [1:0]           ld_off;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [DATA_SIZE-1:0] ext;
  assign bus.wb_stall = state == WAIT_LOAD;
  // select and extend the addressed byte/half of the returned word
  always_comb begin
    byte_sel = bus.dm_rdata[8*ld_off +: 8];
    half_sel = bus.dm_rdata[16*ld_off[1] +: 16];
    ext = ld_f3 == 3'b000 ? {{(DATA_SIZE-8){byte_sel[7]}}, byte_sel} :
          ld_f3 == 3'b100 ? {{(DATA_SIZE-8){1'b0}}, byte_sel} :
          ld_f3 == 3'b001 ? {{(DATA_SIZE-16){half_sel[15]}}, half_sel} :
          ld_f3 == 3'b101 ? {{(DATA_SIZE-16){1'b0}}, half_sel} : bus.dm_rdata;
  end
  // retire ALU ops immediately, hold loads until read data returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ld_we          <= 1'b0;
      ld_rd          <= '0;
      ld_f3          <= '0;
      ld_off         <= '0;
      bus.write_reg  <= 1'b0;
      bus.rd_addr    <= '0;
      bus.write_data <= '0;
      bus.retire_cnt <= '0;
    end else begin
      bus.write_reg <= 1'b0;
      if (state == IDLE) begin
        if (bus.mem_valid && !bus.mem_to_reg) begin
          bus.write_reg  <= bus.mem_reg_write && bus.mem_rd_addr != 5'd0;
          bus.rd_addr    <= bus.mem_rd_addr;
          bus.write_data <= bus.mem_alu_result;
          bus.retire_cnt <= bus.retire_cnt + 1'b1;
        end else if (bus.mem_valid) begin
          ld_we  <= bus.mem_reg_write;
          ld_rd  <= bus.mem_rd_addr;
          ld_f3  <= bus.mem_funct3;
          ld_off <= bus.mem_alu_result[1:0];
          state  <= WAIT_LOAD;
        end
      end else if (bus.dm_rvalid) begin
        bus.write_reg  <= ld_we && ld_rd != 5'd0;
        bus.rd_addr    <= ld_rd;
        bus.write_data <= ext;
        bus.retire_cnt <= bus.retire_cnt + 1'b1;
        state          <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed write-back stage bench checked against a transaction-level model
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  wb_if #(.DATA_SIZE(32), .CNT_SIZE(32)) b();
  wb_if #(.DATA_SIZE(32), .CNT_SIZE(4))  b4();
  wb_stage #(.DATA_SIZE(32), .CNT_SIZE(32)) dut  (.clk(clk), .rst(rst), .bus(b));
  wb_stage #(.DATA_SIZE(32), .CNT_SIZE(4))  dut4 (.clk(clk), .rst(rst), .bus(b4));
  assign b4.mem_valid      = b.mem_valid;
  assign b4.mem_reg_write  = b.mem_reg_write;
  assign b4.mem_to_reg     = b.mem_to_reg;
  assign b4.mem_rd_addr    = b.mem_rd_addr;
  assign b4.mem_alu_result = b.mem_alu_result;
  assign b4.mem_funct3     = b.mem_funct3;
  assign b4.dm_rdata       = b.dm_rdata;
  assign b4.dm_rvalid      = b.dm_rvalid;
  always #5 clk = ~clk;

  // model: one pending load at most; each retirement yields one (we, rd, data) result
  logic        busy, m_we, p_we;
  logic [4:0]  m_rd, p_rd;
  logic [31:0] m_wd, m_cnt, p_addr;
  logic [2:0]  p_f3;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] bv, hv;
    bv = (w >> (8 * off)) & 32'hFF;
    hv = (w >> (16 * off[1])) & 32'hFFFF;
    if (f3 == 3'b000) return bv >= 32'd128 ? bv - 32'd256 : bv;
    if (f3 == 3'b100) return bv;
    if (f3 == 3'b001) return hv >= 32'd32768 ? hv - 32'd65536 : hv;
    if (f3 == 3'b101) return hv;
    return w;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 0; m_we <= 0; m_rd <= 0; m_wd <= 0; m_cnt <= 0;
      p_we <= 0; p_rd <= 0; p_f3 <= 0; p_addr <= 0;
    end else begin
      m_we <= 0;
      if (busy) begin
        if (b.dm_rvalid) begin
          busy  <= 0;
          m_we  <= p_we && p_rd != 0;
          m_rd  <= p_rd;
          m_wd  <= extend(p_f3, p_addr[1:0], b.dm_rdata);
          m_cnt <= m_cnt + 1;
        end
      end else if (b.mem_valid && b.mem_to_reg) begin
        busy <= 1; p_we <= b.mem_reg_write; p_rd <= b.mem_rd_addr;
        p_f3 <= b.mem_funct3; p_addr <= b.mem_alu_result;
      end else if (b.mem_valid) begin
        m_we  <= b.mem_reg_write && b.mem_rd_addr != 0;
        m_rd  <= b.mem_rd_addr;
        m_wd  <= b.mem_alu_result;
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("stall", {31'd0, b.wb_stall}, {31'd0, busy});
    chk("write_reg", {31'd0, b.write_reg}, {31'd0, m_we});
    chk("rd_addr", {27'd0, b.rd_addr}, {27'd0, m_rd});
    chk("write_data", b.write_data, m_wd);
    chk("retire_cnt", b.retire_cnt, m_cnt);
    chk("retire_cnt4", {28'd0, b4.retire_cnt}, {28'd0, m_cnt[3:0]});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d, input logic we);
    b.mem_valid = 1; b.mem_to_reg = 0; b.mem_rd_addr = rd; b.mem_alu_result = d;
    b.mem_reg_write = we; b.mem_funct3 = 3'b010;
    cyc();
    b.mem_valid = 0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                      input logic we, input logic [31:0] rdata, input int waits,
                      output logic [31:0] wd, output int stalls, output int writes);
    b.mem_valid = 1; b.mem_to_reg = 1; b.mem_rd_addr = rd; b.mem_alu_result = addr;
    b.mem_funct3 = f3; b.mem_reg_write = we;
    cyc();
    stalls = int'(b.wb_stall);
    writes = int'(b.write_reg);
    b.mem_to_reg = 0; b.mem_rd_addr = 5'd31; b.mem_alu_result = 32'hDEAD0000; b.mem_reg_write = 1;
    b.dm_rdata = ~rdata;
    repeat (waits) begin
      cyc();
      stalls += int'(b.wb_stall);
      writes += int'(b.write_reg);
    end
    b.mem_valid = 0; b.dm_rvalid = 1; b.dm_rdata = rdata;
    cyc();
    b.dm_rvalid = 0;
    wd = b.write_data;
    writes += int'(b.write_reg);
  endtask

  logic [31:0] wd, cnt0;
  int st, wr;

  initial begin
    b.mem_valid = 0; b.mem_reg_write = 0; b.mem_to_reg = 0; b.mem_rd_addr = 0;
    b.mem_alu_result = 0; b.mem_funct3 = 0; b.dm_rdata = 0; b.dm_rvalid = 0;
    #1 rst = 0;
    cyc(); cyc();
    chk("rst_write_data", b.write_data, 32'd0);
    chk("rst_cnt", b.retire_cnt, 32'd0);
    rst = 1;
    cyc();
    alu(5'd5, 32'h12345678, 1);
    chk("t1_we", {31'd0, b.write_reg}, 32'd1);
    chk("t1_rd", {27'd0, b.rd_addr}, 32'd5);
    chk("t1_wd", b.write_data, 32'h12345678);
    chk("t1_cnt", b.retire_cnt, 32'd1);
    cyc();
    chk("t1_pulse", {31'd0, b.write_reg}, 32'd0);
    chk("t1_hold", b.write_data, 32'h12345678);
    load(5'd7, 32'h00001003, 3'b000, 1, 32'h80FF7F01, 0, wd, st, wr);
    chk("t2_lb3", wd, 32'hFFFFFF80);
    chk("t2_rd", {27'd0, b.rd_addr}, 32'd7);
    load(5'd7, 32'h00001001, 3'b000, 1, 32'h80FF7F01, 1, wd, st, wr);
    chk("t2_lb1", wd, 32'h0000007F);
    load(5'd8, 32'h00002002, 3'b101, 1, 32'h80017FFF, 0, wd, st, wr);
    chk("t3_lhu2", wd, 32'h00008001);
    load(5'd8, 32'h00002002, 3'b001, 1, 32'h80017FFF, 0, wd, st, wr);
    chk("t3_lh2", wd, 32'hFFFF8001);
    load(5'd8, 32'h00002003, 3'b101, 1, 32'h80017FFF, 0, wd, st, wr);
    chk("t3_lhu3", wd, 32'h00008001);
    load(5'd8, 32'h00002003, 3'b001, 1, 32'h80017FFF, 0, wd, st, wr);
    chk("t3_lh3", wd, 32'hFFFF8001);
    load(5'd9, 32'h00003000, 3'b100, 1, 32'h000000F0, 0, wd, st, wr);
    chk("lbu0", wd, 32'h000000F0);
    load(5'd9, 32'h00003000, 3'b011, 1, 32'h89ABCDEF, 0, wd, st, wr);
    chk("other_f3", wd, 32'h89ABCDEF);
    load(5'd10, 32'h00004000, 3'b010, 1, 32'hCAFEBABE, 3, wd, st, wr);
    chk("t4_lw", wd, 32'hCAFEBABE);
    chk("t4_stall_cycles", st, 32'd4);
    chk("t4_writes", wr, 32'd1);
    chk("t4_stall_done", {31'd0, b.wb_stall}, 32'd0);
    alu(5'd11, 32'h0BADF00D, 1);
    chk("t4_next_we", {31'd0, b.write_reg}, 32'd1);
    chk("t4_next_wd", b.write_data, 32'h0BADF00D);
    cnt0 = b.retire_cnt;
    alu(5'd0, 32'h55555555, 1);
    chk("t5_alu_we", {31'd0, b.write_reg}, 32'd0);
    chk("t5_alu_cnt", b.retire_cnt, cnt0 + 32'd1);
    load(5'd0, 32'h00005000, 3'b010, 1, 32'h77777777, 1, wd, st, wr);
    chk("t5_ld_writes", wr, 32'd0);
    chk("t5_ld_cnt", b.retire_cnt, cnt0 + 32'd2);
    b.mem_valid = 1; b.mem_to_reg = 1; b.mem_rd_addr = 5'd12; b.mem_alu_result = 32'h6000;
    b.mem_funct3 = 3'b010; b.mem_reg_write = 1;
    cyc();
    b.mem_valid = 0;
    chk("t6_stall_pre", {31'd0, b.wb_stall}, 32'd1);
    rst = 0;
    #1;
    chk("t6_stall", {31'd0, b.wb_stall}, 32'd0);
    chk("t6_wd", b.write_data, 32'd0);
    chk("t6_cnt", b.retire_cnt, 32'd0);
    cyc();
    rst = 1;
    b.dm_rvalid = 1; b.dm_rdata = 32'h12121212;
    cyc(); cyc();
    b.dm_rvalid = 0;
    chk("t6_no_write", {31'd0, b.write_reg}, 32'd0);
    chk("t6_cnt_after", b.retire_cnt, 32'd0);
    for (int i = 0; i < 16; i++) alu(5'(i + 1), 32'(i * 3), 1);
    chk("wrap_cnt4", {28'd0, b4.retire_cnt}, 32'd0);
    chk("wrap_cnt32", b.retire_cnt, 32'd16);
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
